// File: rtl/clk_pattern_gen.sv
// Programmable slow-clock generator: high/low durations counted in clk_fst cycles,
// with a one-deep pending configuration that is applied only at a period boundary.
module clk_pattern_gen #(
   parameter int W      = 16,
   parameter int HT_RST = 4,
   parameter int LT_RST = 4
) (
   input  logic         clk_fst,
   input  logic         reset_n,
   input  logic         en,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] ht_in,
   input  logic [W-1:0] lt_in,
   output logic         clk_out,
   output logic         period_done,
   output logic [W-1:0] period_cnt,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   localparam logic [W-1:0] ONE      = W'(1);
   localparam logic [W-1:0] HT_RST_V = W'(HT_RST);
   localparam logic [W-1:0] LT_RST_V = W'(LT_RST);

   state_t       state_reg, state_next;
   logic [W-1:0] cnt_reg, cnt_next;
   logic [W-1:0] ht_act_reg, lt_act_reg;
   logic [W-1:0] ht_pnd_reg, lt_pnd_reg;
   logic         pnd_vld_reg;
   logic [W-1:0] period_cnt_reg;
   logic         clk_out_reg;
   logic         last_low;
   logic         apply;
   logic         accept;
   logic [W-1:0] ht_clamp, lt_clamp;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      last_low   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (en) begin
               state_next = HIGH;
               cnt_next   = ONE;
            end
         end
         HIGH: begin
            if (cnt_reg == ht_act_reg) begin
               state_next = LOW;
               cnt_next   = ONE;
            end else begin
               cnt_next = cnt_reg + ONE;
            end
         end
         LOW: begin
            if (cnt_reg == lt_act_reg) begin
               last_low = 1'b1;
               // A dropped en only takes effect here, so the last period is never cut short
               if (en) begin
                  state_next = HIGH;
                  cnt_next   = ONE;
               end else begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            end else begin
               cnt_next = cnt_reg + ONE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Pending setting is swapped in only at a period start, or at any time while idle
   assign apply  = pnd_vld_reg &&
                   (((state_next == HIGH) && (state_reg != HIGH)) || (state_reg == IDLE));
   assign accept = cfg_valid && !pnd_vld_reg;

   assign ht_clamp = (ht_in == '0) ? ONE : ht_in;
   assign lt_clamp = (lt_in == '0) ? ONE : lt_in;

   always_ff @(posedge clk_fst or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         clk_out_reg    <= 1'b0;
         period_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         clk_out_reg <= (state_next == HIGH);
         if (last_low) begin
            period_cnt_reg <= period_cnt_reg + ONE;
         end
      end
   end

   always_ff @(posedge clk_fst or negedge reset_n) begin
      if (!reset_n) begin
         ht_act_reg  <= HT_RST_V;
         lt_act_reg  <= LT_RST_V;
         ht_pnd_reg  <= '0;
         lt_pnd_reg  <= '0;
         pnd_vld_reg <= 1'b0;
      end else begin
         if (apply) begin
            ht_act_reg <= ht_pnd_reg;
            lt_act_reg <= lt_pnd_reg;
         end
         // accept and apply are mutually exclusive: one needs pnd_vld low, the other high
         if (accept) begin
            ht_pnd_reg  <= ht_clamp;
            lt_pnd_reg  <= lt_clamp;
            pnd_vld_reg <= 1'b1;
         end else if (apply) begin
            pnd_vld_reg <= 1'b0;
         end
      end
   end

   assign cfg_ready   = !pnd_vld_reg;
   assign busy        = (state_reg != IDLE);
   assign period_done = last_low;
   assign clk_out     = clk_out_reg;
   assign period_cnt  = period_cnt_reg;

endmodule

// File: tb/tb_clk_pattern_gen.sv
// Self-checking bench for clk_pattern_gen: directed scenarios plus random en/config
// traffic against a period-position reference model; a narrow second instance covers wrap.
module tb_clk_pattern_gen;

   localparam int W  = 16;
   localparam int WW = 8;   // narrow counter so the wrap is reachable in a short run

   logic          clk_fst = 1'b0;
   logic          reset_n = 1'b0;
   logic          en = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [W-1:0]  ht_in = '0;
   logic [W-1:0]  lt_in = '0;
   logic          cfg_ready, clk_out, period_done, busy;
   logic [W-1:0]  period_cnt;

   logic          en_w = 1'b0;
   logic          cfg_valid_w = 1'b0;
   logic [WW-1:0] ht_in_w = '0;
   logic [WW-1:0] lt_in_w = '0;
   logic          cfg_ready_w, clk_out_w, period_done_w, busy_w;
   logic [WW-1:0] period_cnt_w;

   clk_pattern_gen #(.W(W), .HT_RST(4), .LT_RST(4)) dut (
      .clk_fst     (clk_fst),
      .reset_n     (reset_n),
      .en          (en),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .ht_in       (ht_in),
      .lt_in       (lt_in),
      .clk_out     (clk_out),
      .period_done (period_done),
      .period_cnt  (period_cnt),
      .busy        (busy)
   );

   clk_pattern_gen #(.W(WW), .HT_RST(4), .LT_RST(4)) dut_wrap (
      .clk_fst     (clk_fst),
      .reset_n     (reset_n),
      .en          (en_w),
      .cfg_valid   (cfg_valid_w),
      .cfg_ready   (cfg_ready_w),
      .ht_in       (ht_in_w),
      .lt_in       (lt_in_w),
      .clk_out     (clk_out_w),
      .period_done (period_done_w),
      .period_cnt  (period_cnt_w),
      .busy        (busy_w)
   );

   always #5 clk_fst = ~clk_fst;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: position inside the current period rather than a phase state
   int m_run, m_pos, m_ht, m_lt, m_pv, m_pht, m_plt, m_pcnt;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
   endtask

   function automatic void model_reset();
      m_run = 0; m_pos = 0; m_ht = 4; m_lt = 4;
      m_pv = 0; m_pht = 0; m_plt = 0; m_pcnt = 0;
   endfunction

   function automatic void model_step(input logic e, input logic cv,
                                      input logic [W-1:0] hi, input logic [W-1:0] li);
      bit acc = cv && (m_pv == 0);
      if (m_run == 0) begin
         if (m_pv != 0) begin m_ht = m_pht; m_lt = m_plt; m_pv = 0; end
         if (e) begin m_run = 1; m_pos = 0; end
      end else if (m_pos == m_ht + m_lt - 1) begin
         m_pcnt = (m_pcnt + 1) % (1 << W);
         if (e) begin
            m_pos = 0;
            if (m_pv != 0) begin m_ht = m_pht; m_lt = m_plt; m_pv = 0; end
         end else begin
            m_run = 0;
         end
      end else begin
         m_pos++;
      end
      if (acc) begin
         m_pht = (hi == 0) ? 1 : int'(hi);
         m_plt = (li == 0) ? 1 : int'(li);
         m_pv  = 1;
         $display("cfg accepted cyc=%0d ht=%0d lt=%0d", cyc, m_pht, m_plt);
      end
   endfunction

   task automatic check_outputs();
      check_val("clk_out",     {31'b0, clk_out},     ((m_run != 0) && (m_pos < m_ht)) ? 1 : 0);
      check_val("period_done", {31'b0, period_done},
                ((m_run != 0) && (m_pos == m_ht + m_lt - 1)) ? 1 : 0);
      check_val("busy",        {31'b0, busy},        (m_run != 0) ? 1 : 0);
      check_val("cfg_ready",   {31'b0, cfg_ready},   (m_pv == 0) ? 1 : 0);
      check_val("period_cnt",  32'(period_cnt),      m_pcnt);
   endtask

   task automatic tick();
      @(posedge clk_fst);
      model_step(en, cfg_valid, ht_in, lt_in);
      @(negedge clk_fst);
      cyc++;
      check_outputs();
   endtask

   task automatic offer_cfg(input int h, input int l);
      int g = 0;
      bit took = 0;
      cfg_valid = 1'b1;
      ht_in = W'(h);
      lt_in = W'(l);
      while (!took && g < 40) begin
         took = (m_pv == 0);
         tick();
         g++;
      end
      cfg_valid = 1'b0;
   endtask

   initial begin
      int g;
      model_reset();
      #1;
      $display("reset state");
      check_outputs();
      check_val("w_pcnt_rst",  32'(period_cnt_w), 0);
      check_val("w_ready_rst", {31'b0, cfg_ready_w}, 1);
      @(negedge clk_fst);
      @(negedge clk_fst);
      reset_n = 1'b1;

      $display("default run 4/4");
      en = 1'b1;
      repeat (24) tick();

      $display("mid-period reconfig 3/5");
      g = 0;
      while (!((m_run != 0) && (m_pos < m_ht)) && g < 40) begin tick(); g++; end
      check_val("wait_high", {31'b0, clk_out}, 1);
      offer_cfg(3, 5);
      repeat (24) tick();

      $display("zero clamp");
      offer_cfg(0, 0);
      repeat (12) tick();

      $display("graceful stop");
      offer_cfg(4, 4);
      g = 0;
      while (!((m_run != 0) && (m_pos == 1) && (m_ht == 4) && (m_pv == 0)) && g < 60) begin
         tick();
         g++;
      end
      check_val("stop_2nd_high", {31'b0, clk_out}, 1);
      en = 1'b0;
      repeat (12) tick();
      check_val("stop_idle_busy", {31'b0, busy}, 0);

      $display("random traffic");
      en = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(15) == 0) en = ~en;
         cfg_valid = ($urandom_range(7) == 0);
         ht_in = 16'($urandom_range(6));
         lt_in = 16'($urandom_range(6));
         tick();
      end
      cfg_valid = 1'b0;

      $display("async reset mid-LOW");
      en = 1'b1;
      offer_cfg(3, 5);
      g = 0;
      while (!((m_run != 0) && (m_ht == 3) && (m_lt == 5) && (m_pos == 4) && (m_pv == 0))
             && g < 80) begin
         tick();
         g++;
      end
      check_val("pre_rst_busy", {31'b0, busy}, 1);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk_fst);
      reset_n = 1'b1;
      repeat (20) tick();
      en = 1'b0;

      $display("wrap run on narrow instance");
      cfg_valid_w = 1'b1;
      ht_in_w = '0;
      lt_in_w = '0;
      @(posedge clk_fst);
      @(negedge clk_fst);
      cfg_valid_w = 1'b0;
      en_w = 1'b1;
      @(posedge clk_fst);
      @(negedge clk_fst);
      for (int i = 0; i < 2 * (1 << WW) + 20; i++) begin
         cyc++;
         check_val("w_clk_out",     {31'b0, clk_out_w},     (i % 2 == 0) ? 1 : 0);
         check_val("w_period_done", {31'b0, period_done_w}, (i % 2 == 1) ? 1 : 0);
         check_val("w_period_cnt",  32'(period_cnt_w),      (i / 2) % (1 << WW));
         @(posedge clk_fst);
         @(negedge clk_fst);
      end
      check_val("w_busy", {31'b0, busy_w}, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog");
   end

endmodule
